// File: rtl/period_meter_amisha.sv
// period_meter_amisha
//   FSMD period / high-pulse-width meter. In mode 0 it measures the
//   rising-to-rising period summed over n periods. In mode 1 it measures the
//   rising-to-falling high width. Both results are in units of CLK_DIV clocks.
//   The result saturates on overflow. A missing start edge raises a timeout.
//
// Optional feature: define SI_SYNC_EN to pass si_amisha through a 2-flop
//   synchroniser before edge detection. Leave it undefined when si_amisha is
//   already synchronous to clk_amisha.
//
// Ports
//   clk_amisha        in   clock, rising edge
//   reset_amisha      in   asynchronous active-high reset
//   start_amisha      in   start request, accepted only while ready_amisha=1
//   abort_amisha      in   abandon a measurement in WAIT/COUNT
//   mode_amisha       in   0 = period (rise->rise), 1 = high width (rise->fall)
//   n_amisha          in   periods to accumulate in mode 0 (0 treated as 1)
//   si_amisha         in   measured signal
//   ready_amisha      out  high in IDLE
//   done_tick_amisha  out  one-cycle pulse when a result is complete
//   prd_amisha        out  result in CLK_DIV units (held until next COUNT)
//   ovf_amisha        out  result saturated
//   tmo_amisha        out  no start edge before the timeout
module period_meter_amisha #(
    parameter int CLK_DIV       = 50000,
    parameter int PW            = 16,
    parameter int NW            = 4,
    parameter int TIMEOUT_UNITS = 1000
) (
    input  logic          clk_amisha,
    input  logic          reset_amisha,
    input  logic          start_amisha,
    input  logic          abort_amisha,
    input  logic          mode_amisha,
    input  logic [NW-1:0] n_amisha,
    input  logic          si_amisha,
    output logic          ready_amisha,
    output logic          done_tick_amisha,
    output logic [PW-1:0] prd_amisha,
    output logic          ovf_amisha,
    output logic          tmo_amisha
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int WW = $clog2(TIMEOUT_UNITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
    localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT_UNITS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_COUNT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] t_q, t_d;        // clocks within the current unit
    logic [WW-1:0] w_q, w_d;        // units spent waiting for the start edge
    logic [PW-1:0] p_q, p_d;        // accumulated units; doubles as the result
    logic [NW-1:0] e_q, e_d;        // non-terminating rises seen in COUNT
    logic [NW-1:0] n_q, n_d;
    logic          mode_q, mode_d;
    logic          ovf_q, ovf_d;
    logic          tmo_q, tmo_d;
    logic          dly_q;
    logic          s;
    logic          rise, fall, term;

`ifdef SI_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) sync_q <= 2'b00;
        else              sync_q <= {sync_q[0], si_amisha};
    end
    assign s = sync_q[1];
`else
    assign s = si_amisha;
`endif

    assign rise = s & ~dly_q;
    assign fall = dly_q & ~s;
    // The terminating edge in mode 0 is the n-th rise after the start rise.
    assign term = mode_q ? fall : (rise && (e_q == n_q - NW'(1)));

    always_comb begin
        state_d          = state_q;
        t_d              = t_q;
        w_d              = w_q;
        p_d              = p_q;
        e_d              = e_q;
        n_d              = n_q;
        mode_d           = mode_q;
        ovf_d            = ovf_q;
        tmo_d            = tmo_q;
        ready_amisha     = 1'b0;
        done_tick_amisha = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_amisha = 1'b1;
                if (start_amisha) begin
                    mode_d  = mode_amisha;
                    n_d     = (n_amisha == '0) ? NW'(1) : n_amisha;
                    ovf_d   = 1'b0;
                    tmo_d   = 1'b0;
                    w_d     = '0;
                    t_d     = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // p keeps the previous result until the new measurement starts.
                if (abort_amisha) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    t_d     = '0;
                    p_d     = '0;
                    e_d     = '0;
                    state_d = S_COUNT;
                end else if (w_q == W_LAST) begin
                    tmo_d   = 1'b1;
                    p_d     = '0;
                    state_d = S_DONE;
                end else if (t_q == T_LAST) begin
                    t_d = '0;
                    w_d = w_q + WW'(1);
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            S_COUNT: begin
                // On the terminating cycle t/p freeze, so p = floor((T-1)/CLK_DIV).
                if (abort_amisha) begin
                    state_d = S_IDLE;
                end else if (term) begin
                    state_d = S_DONE;
                end else begin
                    if (!mode_q && rise) e_d = e_q + NW'(1);
                    if (t_q == T_LAST) begin
                        if (&p_q) begin
                            ovf_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            t_d = '0;
                            p_d = p_q + PW'(1);
                        end
                    end else begin
                        t_d = t_q + TW'(1);
                    end
                end
            end
            S_DONE: begin
                done_tick_amisha = 1'b1;
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            w_q     <= '0;
            p_q     <= '0;
            e_q     <= '0;
            n_q     <= NW'(1);
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            p_q     <= p_d;
            e_q     <= e_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
            tmo_q   <= tmo_d;
            dly_q   <= s;
        end
    end

    assign prd_amisha = p_q;
    assign ovf_amisha = ovf_q;
    assign tmo_amisha = tmo_q;

endmodule

// File: tb/tb_period_meter_amisha.sv
// Testbench for period_meter_amisha (CLK_DIV=10, PW=8, NW=4, TIMEOUT_UNITS=20).
// Stimulus pushes the expected result for each measurement into a queue.
// An independent monitor pops and compares the queue on every done_tick.
module tb_period_meter_amisha;
    localparam int CLK_DIV = 10;
    localparam int PW      = 8;
    localparam int NW      = 4;
    localparam int TMO     = 20;

    logic          clk = 1'b0;
    logic          rst, start, abort, mode, si;
    logic [NW-1:0] n;
    logic          ready, done, ovf, tmo;
    logic [PW-1:0] prd;

    typedef struct packed {
        logic [PW-1:0] prd;
        logic          ovf;
        logic          tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    period_meter_amisha #(.CLK_DIV(CLK_DIV), .PW(PW), .NW(NW), .TIMEOUT_UNITS(TMO)) dut (
        .clk_amisha      (clk),
        .reset_amisha    (rst),
        .start_amisha    (start),
        .abort_amisha    (abort),
        .mode_amisha     (mode),
        .n_amisha        (n),
        .si_amisha       (si),
        .ready_amisha    (ready),
        .done_tick_amisha(done),
        .prd_amisha      (prd),
        .ovf_amisha      (ovf),
        .tmo_amisha      (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: T clocks between start and end edge gives floor((T-1)/CLK_DIV),
    // saturating at all-ones with ovf when the quotient does not fit in PW bits.
    function automatic exp_t model(bit m, int nn, int per, int hi);
        exp_t e;
        int   neff = (nn == 0) ? 1 : nn;
        int   tt   = m ? hi : neff * per;
        int   q    = (tt - 1) / CLK_DIV;
        e.tmo = 1'b0;
        e.ovf = (q > (2 ** PW - 1));
        e.prd = e.ovf ? {PW{1'b1}} : PW'(q);
        return e;
    endfunction

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        bit   was_done;
        was_done = 1'b0;
        forever begin
            @(negedge clk);
            if (was_done) begin
                check("done_one_cycle", int'(done), 0);
                check("ready_after_done", int'(ready), 1);
            end
            was_done = 1'b0;
            if (!rst && done) begin
                was_done = 1'b1;
                txn++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=prd %0d required=no done_tick", prd);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: prd=%0d ovf=%0d tmo=%0d (exp prd=%0d ovf=%0d tmo=%0d)",
                             txn, prd, ovf, tmo, e.prd, e.ovf, e.tmo);
                    check("prd", int'(prd), int'(e.prd));
                    check("ovf", int'(ovf), int'(e.ovf));
                    check("tmo", int'(tmo), int'(e.tmo));
                end
            end
        end
    end

    task automatic wait_ready(int budget);
        int k = 0;
        while (!ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("ready_wait", int'(ready), 1);
    endtask

    task automatic wait_drain(int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Ends on the negedge after the start was sampled; mode/n are then
    // scrambled so the DUT must rely on its latched copies.
    task automatic do_start(bit m, int nn);
        wait_ready(5000);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        n     = NW'(nn);
        @(negedge clk);
        start = 1'b0;
        mode  = 1'($urandom);
        n     = NW'($urandom);
    endtask

    task automatic pulse(int h, int l);
        si = 1'b1;
        repeat (h) @(negedge clk);
        si = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic run_meas(bit m, int nn, int per, int hi, int lead);
        int neff = (nn == 0) ? 1 : nn;
        exp_q.push_back(model(m, nn, per, hi));
        do_start(m, nn);
        repeat (lead) @(negedge clk);
        if (!m) begin
            for (int i = 0; i <= neff; i++) pulse(hi, per - hi);
        end else begin
            pulse(hi, 20);
            pulse(3, 5);   // rise after the measurement must be ignored
        end
        wait_drain(200);
    endtask

    initial begin : stim
        int   cnt;
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        n     = '0;
        si    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_prd", int'(prd), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_tmo", int'(tmo), 0);
        rst = 1'b0;
        @(negedge clk);

        run_meas(1'b0, 1, 255, 100, 6);   // prd 25
        run_meas(1'b1, 0, 0, 75, 8);      // prd 7
        run_meas(1'b0, 4, 101, 50, 5);    // prd 40
        run_meas(1'b0, 0, 101, 30, 7);    // n=0 -> 1, prd 10

        // Timeout with si held low
        e.prd = '0;
        e.ovf = 1'b0;
        e.tmo = 1'b1;
        exp_q.push_back(e);
        do_start(1'b0, 1);
        cnt = 1;
        while (!done && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        check("tmo_latency_in_window", int'(cnt >= 195 && cnt <= 210), 1);
        wait_drain(20);

        // Set up a nonzero result, then reset in the middle of COUNT
        run_meas(1'b0, 1, 120, 60, 5);    // prd 11
        do_start(1'b0, 1);
        repeat (5) @(negedge clk);
        si = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_prd", int'(prd), 0);
        check("midrst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        si  = 1'b0;
        repeat (3) @(negedge clk);

        // Abort in COUNT after 56 counting clocks -> partial prd 5
        do_start(1'b0, 3);
        repeat (5) @(negedge clk);
        si = 1'b1;
        repeat (57) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_count_ready", int'(ready), 1);
        check("abort_count_prd", int'(prd), 5);
        si = 1'b0;
        repeat (3) @(negedge clk);

        // Abort in WAIT keeps the partial result
        do_start(1'b1, 0);
        repeat (10) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_wait_ready", int'(ready), 1);
        check("abort_wait_prd", int'(prd), 5);
        check("abort_wait_tmo", int'(tmo), 0);
        repeat (5) @(negedge clk);

        run_meas(1'b0, 1, 3000, 1500, 5); // overflow: prd 255, ovf 1

        for (int r = 0; r < 12; r++) begin
            bit m;
            int nn, per, hi, lead;
            m    = 1'($urandom_range(0, 1));
            nn   = $urandom_range(0, 15);
            per  = $urandom_range(4, 220);
            hi   = m ? $urandom_range(1, 400) : $urandom_range(1, per - 1);
            lead = $urandom_range(4, 40);
            run_meas(m, nn, per, hi, lead);
        end

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
